// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: stage 1 adds the low half, stage 2 finishes the upper half and forms flags.
// Valid/ready handshake with full backpressure; up to two beats buffered.
module alu_pipe #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic             set
);

    localparam int unsigned LO = WIDTH / 2;
    localparam int unsigned HI = WIDTH - LO;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    logic          v1_q, v1_d;
    logic [LO-1:0] lo_res_q, lo_res_d;
    logic          lo_carry_q, lo_carry_d;
    logic [HI-1:0] a_hi_q, a_hi_d;
    logic [HI-1:0] b_hi_q, b_hi_d;
    logic [2:0]    op_q, op_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;
    logic             set_q, set_d;

    logic s2_ready;
    logic accept;
    logic xfer;

    assign s2_ready = !out_valid_q || out_ready;
    assign in_ready = !v1_q || s2_ready;
    assign accept   = in_valid && in_ready;
    assign xfer     = v1_q && s2_ready;

    // Stage 1: low-half add or logic op, capture upper operand halves
    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic [LO:0]      lo_sum;

    always_comb begin
        b_eff      = b;
        c0         = 1'b0;
        v1_d       = v1_q;
        lo_res_d   = lo_res_q;
        lo_carry_d = lo_carry_q;
        a_hi_d     = a_hi_q;
        b_hi_d     = b_hi_q;
        op_d       = op_q;

        if (op == OP_SUB || op == OP_SLT) begin
            b_eff = ~b;
            c0    = 1'b1;
        end else if (op == OP_ADD) begin
            c0 = cin;
        end
        lo_sum = {1'b0, a[LO-1:0]} + {1'b0, b_eff[LO-1:0]} + (LO+1)'(c0);

        if (accept) begin
            v1_d       = 1'b1;
            lo_carry_d = lo_sum[LO];
            a_hi_d     = a[WIDTH-1:LO];
            b_hi_d     = b_eff[WIDTH-1:LO];
            op_d       = op;
            case (op)
                OP_AND:  lo_res_d = a[LO-1:0] & b[LO-1:0];
                OP_OR:   lo_res_d = a[LO-1:0] | b[LO-1:0];
                default: lo_res_d = lo_sum[LO-1:0];
            endcase
        end else if (xfer) begin
            v1_d = 1'b0;
        end
    end

    // Stage 2: upper-half add from registered carry, then result/flag selection
    logic [HI:0]      hi_sum;
    logic             c_msb;
    logic             ar_cout;
    logic             ar_ovf;
    logic             slt_c;
    logic [WIDTH-1:0] res_c;
    logic             cout_c;
    logic             ovf_c;
    logic             set_c;

    always_comb begin
        hi_sum  = {1'b0, a_hi_q} + {1'b0, b_hi_q} + (HI+1)'(lo_carry_q);
        c_msb   = a_hi_q[HI-1] ^ b_hi_q[HI-1] ^ hi_sum[HI-1];
        ar_cout = hi_sum[HI];
        ar_ovf  = c_msb ^ ar_cout;
        slt_c   = hi_sum[HI-1] ^ ar_ovf;

        res_c  = '0;
        cout_c = 1'b0;
        ovf_c  = 1'b0;
        set_c  = 1'b0;
        case (op_q)
            OP_AND: res_c = {a_hi_q & b_hi_q, lo_res_q};
            OP_OR:  res_c = {a_hi_q | b_hi_q, lo_res_q};
            OP_ADD, OP_SUB: begin
                res_c  = {hi_sum[HI-1:0], lo_res_q};
                cout_c = ar_cout;
                ovf_c  = ar_ovf;
            end
            OP_SLT: begin
                res_c  = WIDTH'(slt_c);
                cout_c = ar_cout;
                ovf_c  = ar_ovf;
                set_c  = slt_c;
            end
            default: ;
        endcase

        out_valid_d = out_valid_q;
        result_d    = result_q;
        cout_d      = cout_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;
        set_d       = set_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            result_d    = res_c;
            cout_d      = cout_c;
            overflow_d  = ovf_c;
            zero_d      = ~|res_c;
            set_d       = set_c;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            lo_res_q    <= '0;
            lo_carry_q  <= 1'b0;
            a_hi_q      <= '0;
            b_hi_q      <= '0;
            op_q        <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            cout_q      <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            set_q       <= 1'b0;
        end else begin
            v1_q        <= v1_d;
            lo_res_q    <= lo_res_d;
            lo_carry_q  <= lo_carry_d;
            a_hi_q      <= a_hi_d;
            b_hi_q      <= b_hi_d;
            op_q        <= op_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            cout_q      <= cout_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
            set_q       <= set_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign cout      = cout_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;
    assign set       = set_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe at WIDTH 8/16/32: vector table, backpressure and mid-stream reset.
module tb_alu_pipe;

    localparam logic [2:0] ADD = 3'b010;
    localparam logic [2:0] SUB = 3'b110;
    localparam logic [2:0] SLT = 3'b111;
    localparam logic [2:0] AND = 3'b000;
    localparam logic [2:0] OR  = 3'b001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] a_w = '0, b_w = '0;
    logic [2:0]  op_w = '0;
    logic        cin_w = 1'b0, in_valid_w = 1'b0;
    logic        out_ready16 = 1'b1;
    int          sel = 16;

    always #5 clk = ~clk;

    logic        in_ready16, out_valid16, cout16, ovf16, zero16, set16;
    logic [15:0] result16;
    logic        in_ready8, out_valid8, cout8, ovf8, zero8, set8;
    logic [7:0]  result8;
    logic        in_ready32, out_valid32, cout32, ovf32, zero32, set32;
    logic [31:0] result32;

    alu_pipe #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w && (sel == 16)), .in_ready(in_ready16),
        .a(a_w[15:0]), .b(b_w[15:0]), .cin(cin_w), .op(op_w),
        .out_valid(out_valid16), .out_ready(out_ready16), .result(result16),
        .cout(cout16), .overflow(ovf16), .zero(zero16), .set(set16)
    );

    alu_pipe #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w && (sel == 8)), .in_ready(in_ready8),
        .a(a_w[7:0]), .b(b_w[7:0]), .cin(cin_w), .op(op_w),
        .out_valid(out_valid8), .out_ready(1'b1), .result(result8),
        .cout(cout8), .overflow(ovf8), .zero(zero8), .set(set8)
    );

    alu_pipe #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w && (sel == 32)), .in_ready(in_ready32),
        .a(a_w), .b(b_w), .cin(cin_w), .op(op_w),
        .out_valid(out_valid32), .out_ready(1'b1), .result(result32),
        .cout(cout32), .overflow(ovf32), .zero(zero32), .set(set32)
    );

    logic        in_ready_m, out_valid_m, cout_m, ovf_m, zero_m, set_m;
    logic [31:0] res_m;

    always_comb begin
        in_ready_m  = in_ready16;
        out_valid_m = out_valid16;
        res_m       = 32'(result16);
        cout_m      = cout16;
        ovf_m       = ovf16;
        zero_m      = zero16;
        set_m       = set16;
        if (sel == 8) begin
            in_ready_m  = in_ready8;
            out_valid_m = out_valid8;
            res_m       = 32'(result8);
            cout_m      = cout8;
            ovf_m       = ovf8;
            zero_m      = zero8;
            set_m       = set8;
        end else if (sel == 32) begin
            in_ready_m  = in_ready32;
            out_valid_m = out_valid32;
            res_m       = result32;
            cout_m      = cout32;
            ovf_m       = ovf32;
            zero_m      = zero32;
            set_m       = set32;
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        int          w;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] res;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        set;
    } vec_t;

    vec_t vecs[$];

    task automatic run_vec(input vec_t v, input int k);
        sel = v.w;
        @(negedge clk);
        a_w = v.a; b_w = v.b; op_w = v.op; cin_w = v.cin;
        in_valid_w  = 1'b1;
        out_ready16 = 1'b1;
        #1 chk($sformatf("v%0d_in_ready", k), 32'(in_ready_m), 32'd1);
        @(negedge clk);
        in_valid_w = 1'b0;
        chk($sformatf("v%0d_latency", k), 32'(out_valid_m), 32'd0);
        @(negedge clk);
        chk($sformatf("v%0d_out_valid", k), 32'(out_valid_m), 32'd1);
        chk($sformatf("v%0d_result", k), res_m, v.res);
        chk($sformatf("v%0d_cout", k), 32'(cout_m), 32'(v.cout));
        chk($sformatf("v%0d_overflow", k), 32'(ovf_m), 32'(v.ovf));
        chk($sformatf("v%0d_zero", k), 32'(zero_m), 32'(v.zero));
        chk($sformatf("v%0d_set", k), 32'(set_m), 32'(v.set));
    endtask

    int          sent, rcv, occ;
    bit          held, saw_stall;
    logic [31:0] held_res;

    initial begin
        // w, op, a, b, cin, result, cout, ovf, zero, set
        vecs.push_back('{16, ADD, 32'h7FFF, 32'h0001, 1'b0, 32'h8000, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{16, ADD, 32'h00FF, 32'h0001, 1'b0, 32'h0100, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{16, ADD, 32'hFFFF, 32'h0000, 1'b1, 32'h0000, 1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{16, SUB, 32'h1234, 32'h1234, 1'b0, 32'h0000, 1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{16, SLT, 32'h8000, 32'h0001, 1'b0, 32'h0001, 1'b1, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{16, SLT, 32'h0005, 32'hFFFF, 1'b0, 32'h0000, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{16, SLT, 32'h0001, 32'h0002, 1'b1, 32'h0001, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{16, AND, 32'hF0F0, 32'h3C3C, 1'b1, 32'h3030, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{16, OR,  32'h0F00, 32'h00F0, 1'b0, 32'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{16, AND, 32'h00FF, 32'hFF00, 1'b0, 32'h0000, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{16, 3'b011, 32'hFFFF, 32'hFFFF, 1'b1, 32'h0000, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{16, 3'b100, 32'h8000, 32'h8000, 1'b1, 32'h0000, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{16, SUB, 32'h0000, 32'h0001, 1'b0, 32'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{16, SUB, 32'h0005, 32'h0003, 1'b1, 32'h0002, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{16, SUB, 32'h8000, 32'h0001, 1'b0, 32'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{16, ADD, 32'h8000, 32'h8000, 1'b0, 32'h0000, 1'b1, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{16, ADD, 32'h0001, 32'h0001, 1'b1, 32'h0003, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{8,  ADD, 32'h7F, 32'h01, 1'b0, 32'h80, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{8,  ADD, 32'h0F, 32'h01, 1'b0, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{8,  ADD, 32'hFF, 32'h00, 1'b1, 32'h00, 1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{8,  SLT, 32'h80, 32'h01, 1'b0, 32'h01, 1'b1, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{8,  SLT, 32'h05, 32'hFF, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{32, ADD, 32'h7FFFFFFF, 32'h1, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{32, ADD, 32'h0000FFFF, 32'h1, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{32, ADD, 32'hFFFFFFFF, 32'h0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{32, SLT, 32'h80000000, 32'h1, 1'b0, 32'h00000001, 1'b1, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{32, SLT, 32'h00000005, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0});

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid16), 32'd0);
        chk("rst_result", 32'(result16), 32'd0);
        chk("rst_flags", {28'd0, cout16, ovf16, zero16, set16}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready16), 32'd1);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Backpressure: five ADDs, consumer stalls cycles 2..5
        sel = 16; sent = 0; rcv = 0; held = 1'b0; saw_stall = 1'b0;
        for (int c = 0; c < 40 && rcv < 5; c++) begin
            @(negedge clk);
            out_ready16 = !(c >= 2 && c <= 5);
            #1;
            occ = sent - rcv;
            chk($sformatf("bp_in_ready_c%0d", c), 32'(in_ready16), 32'(!(occ == 2 && !out_ready16)));
            if (!in_ready16) saw_stall = 1'b1;
            if (out_valid16 && !out_ready16) begin
                if (held) chk($sformatf("bp_hold_c%0d", c), 32'(result16), held_res);
                held = 1'b1;
                held_res = 32'(result16);
            end else begin
                held = 1'b0;
            end
            if (out_valid16 && out_ready16) begin
                chk($sformatf("bp_order_%0d", rcv), 32'(result16), 32'(rcv + 1));
                rcv++;
            end
            if (sent < 5) begin
                in_valid_w = 1'b1;
                a_w = 32'(sent + 1); b_w = '0; op_w = ADD; cin_w = 1'b0;
                if (in_ready16) sent++;
            end else begin
                in_valid_w = 1'b0;
            end
        end
        in_valid_w = 1'b0;
        chk("bp_count", 32'(rcv), 32'd5);
        chk("bp_stalled", 32'(saw_stall), 32'd1);
        @(negedge clk);
        chk("bp_no_dup", 32'(out_valid16), 32'd0);

        // Mid-stream reset with two beats held
        out_ready16 = 1'b0;
        in_valid_w = 1'b1; a_w = 32'h11; b_w = '0; op_w = ADD; cin_w = 1'b0;
        @(negedge clk);
        a_w = 32'h22;
        @(negedge clk);
        in_valid_w = 1'b0;
        chk("mrst_pre_valid", 32'(out_valid16), 32'd1);
        chk("mrst_pre_in_ready", 32'(in_ready16), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", 32'(out_valid16), 32'd0);
        chk("mrst_result", 32'(result16), 32'd0);
        chk("mrst_in_ready", 32'(in_ready16), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready16 = 1'b1;
        @(negedge clk);
        chk("mrst_no_ghost", 32'(out_valid16), 32'd0);
        in_valid_w = 1'b1; a_w = 32'h40; b_w = 32'h2; op_w = ADD; cin_w = 1'b0;
        @(negedge clk);
        in_valid_w = 1'b0;
        chk("mrst_no_ghost2", 32'(out_valid16), 32'd0);
        @(negedge clk);
        chk("mrst_first_valid", 32'(out_valid16), 32'd1);
        chk("mrst_first_result", 32'(result16), 32'h42);
        @(negedge clk);
        chk("mrst_drained", 32'(out_valid16), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, two-stage pipelined ALU with valid/ready handshaking. It extends the team's combinational 16-bit carry-lookahead ALU to any even `WIDTH` and splits the carry chain at `WIDTH/2` across a pipeline register, so it can close timing at wider widths. Operand pairs stream in at one per cycle; results and flags emerge two cycles later, with full backpressure support. It sits between the register-read stage and writeback in the datapath, with the same op encoding and flag set as the existing ALU.

## Interface
- `WIDTH`, 16, operand/result width; even and ≥ 4; `LO = WIDTH/2` is the split point.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset: one clock; reset is asynchronous and active-low.
- `in_valid`  in  1  operand beat present.
- `in_ready`  out  1  block accepts the beat this cycle.
- `a`, `b`  in  WIDTH  operands, two's complement.
- `cin`  in  1  carry-in; used by ADD only.
- `op`  in  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; all other codes are reserved.
- `out_valid`  out  1  result beat present.
- `out_ready`  in  1  consumer accepts the result.
- `result`  out  WIDTH  ALU result.
- `cout`  out  1  carry out of the MSB.
- `overflow`  out  1  signed overflow.
- `zero`  out  1  result == 0.
- `set`  out  1  signed a < b (SLT outcome).

## Operation
- Stage 1 (accept): on `in_valid && in_ready`, compute the low `LO` bits.
  - Adder carry-in: `cin` for ADD; 1 for SUB and SLT, with `b` inverted.
  - Register: low result, carry out of bit `LO-1`, upper halves of `a` and effective `b`, `op`, and valid bit `v1`.
- Stage 2: compute the upper half from the registered carry, then form flags.
  - Register result and flags into the output registers, and set `out_valid`.
- Logic ops: bitwise AND/OR of `a` and `b`.
  - `cout`, `overflow` and `set` are 0.
- ADD/SUB result is `a ± b` mod 2^WIDTH.
  - `cout` is the raw adder carry out; for SUB, 1 means no borrow.
  - `overflow` = carry into MSB XOR carry out of MSB.
- SLT: the internal subtract result is discarded.
  - `set` = sub_result[MSB] XOR overflow, so it is correct even when the subtract overflows.
  - `result` = {WIDTH-1 zeros, set}; `cout` and `overflow` are taken from the subtract.
- `set` is 0 for every op except SLT.
- Reserved op: `result` 0, `cout`/`overflow`/`set` 0, `zero` 1.
- `zero` = NOR-reduce of the final `result`, for every op.

## Timing
- Handshake equations:
  - s2_ready = !out_valid || out_ready
  - in_ready = !v1 || s2_ready (combinational)
- The stage-1 → stage-2 transfer occurs when `v1 && s2_ready`.
- Latency: a beat accepted at edge N appears with `out_valid` = 1 after edge N+1.
- Throughput: one beat per cycle while `out_ready` = 1.
- While `out_valid && !out_ready`, `result` and all flags are held stable and no beat is dropped or duplicated. Up to 2 beats are buffered, so `in_ready` falls only when both stages are full and stalled.
- A simultaneous accept at stage 1 and drain at the output in the same cycle is legal and keeps full rate.
- Beats leave in strict acceptance order.
- `rst_n` low, asynchronous, including mid-stream:
  - `v1` = 0 and `out_valid` = 0; `result`, `cout`, `overflow`, `zero`, `set` and all stage-1 registers = 0.
  - In-flight beats are discarded.
  - `in_ready` = 1 from the first cycle after deassertion.
- Inputs are sampled only on accepting edges; `a`, `b`, `op` and `cin` are don't-care when `in_valid` = 0.

## Test plan
All scenarios use WIDTH=16 unless noted.
- ADD `a`=0x7FFF, `b`=0x0001, `cin`=0 → `result`=0x8000, `overflow`=1, `cout`=0, `zero`=0, with `out_valid` two edges after accept.
- Carry across the split:
  - ADD 0x00FF+0x0001, `cin`=0 → 0x0100, `cout`=0.
  - ADD 0xFFFF+0x0000, `cin`=1 → 0x0000, `cout`=1, `zero`=1.
- SUB 0x1234−0x1234 → 0x0000, `zero`=1, `cout`=1, `overflow`=0.
- SLT:
  - `a`=0x8000, `b`=0x0001 → `result`=0x0001, `set`=1, `overflow`=1.
  - `a`=0x0005, `b`=0xFFFF → `result`=0x0000, `set`=0.
- Backpressure: send 5 back-to-back ADDs (i+1 for i=0..4) with `out_ready` low for cycles 2–5.
  - `in_ready` drops once 2 beats are held.
  - Outputs 1..5 arrive in order, held stable while stalled, none lost.
- Reset and width:
  - Assert `rst_n` low with 2 beats in flight → `out_valid` = 0 immediately; the next accepted beat is the first one output.
  - Repeat the ADD/SLT cases at WIDTH=8 and WIDTH=32.
